// File: rtl/sm_imem_loader_if.sv
// Byte-stream program load port of sm_imem_loader.
// The host side (master) issues load_req and presents bytes with byte_valid;
// the loader side (slave) answers with byte_ready. A byte moves on a rising
// clock edge where byte_valid and byte_ready are both high.
interface sm_imem_loader_if;
    logic       load_req;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output load_req,
        output byte_in,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  load_req,
        input  byte_in,
        input  byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/sm_imem_loader.sv
// sm_imem_loader: writable instruction RAM for sm_cpu with a byte-stream loader.
// Stream: LEN_L, LEN_H (word count N), then N little-endian 32-bit words,
// then one XOR checksum byte when SM_IMEM_LOADER_CHECKSUM_EN is defined.
// The core is held in reset (cpu_rst_n = 0) until a load completes cleanly.
// Read port is asynchronous; upper imAddr bits are ignored (wraps modulo SIZE).
module sm_imem_loader #(
    parameter int unsigned SIZE = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    sm_imem_loader_if.slave     bus,
    output logic                busy,
    output logic                err,
    output logic                cpu_rst_n,
    input  logic [31:0]         imAddr,
    output logic [31:0]         imData
);

    localparam int unsigned AW     = $clog2(SIZE);
    localparam logic [16:0] SIZE17 = 17'(SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic [15:0] len_q, len_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [23:0] wbuf_q, wbuf_d;
    logic        err_q, err_d;
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic          xfer;
    logic          len_ovf;
    logic          in_range;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem [SIZE];
    logic          unused_addr_bits;

    // Registered-state decodes for the handshake and core reset.
    assign busy           = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                            (state_q == S_DATA) || (state_q == S_CSUM);
    assign bus.byte_ready = busy;
    assign err            = err_q;
    assign cpu_rst_n      = (state_q == S_DONE) && !err_q;

    assign xfer     = bus.byte_valid && bus.byte_ready;
    assign len_ovf  = {1'b0, len_q} > SIZE17;
    assign in_range = {1'b0, wcnt_q} < SIZE17;

    // State register and load counters; RAM is deliberately outside this reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            len_q   <= '0;
            bcnt_q  <= '0;
            wbuf_q  <= '0;
            err_q   <= 1'b0;
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            len_q   <= len_d;
            bcnt_q  <= bcnt_d;
            wbuf_q  <= wbuf_d;
            err_q   <= err_d;
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Next-state logic: byte parsing, word assembly and RAM write strobe.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        len_d     = len_q;
        bcnt_d    = bcnt_q;
        wbuf_d    = wbuf_q;
        err_d     = err_q;
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        mem_we    = 1'b0;
        mem_waddr = wcnt_q[AW-1:0];
        mem_wdata = {bus.byte_in, wbuf_q};

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.load_req) begin
                    state_d = S_LEN0;
                    wcnt_d  = '0;
                    bcnt_d  = '0;
                    err_d   = 1'b0;
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end

            S_LEN0: begin
                if (xfer) begin
                    len_d[7:0] = bus.byte_in;
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ bus.byte_in;
`endif
                    state_d    = S_LEN1;
                end
            end

            S_LEN1: begin
                if (xfer) begin
                    len_d[15:8] = bus.byte_in;
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
                    csum_d      = csum_q ^ bus.byte_in;
`endif
                    if ({bus.byte_in, len_q[7:0]} != 16'd0) begin
                        state_d = S_DATA;
                    end else begin
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        // N = 0 can never overflow; len_q is not yet complete here.
                        state_d = S_DONE;
                        err_d   = 1'b0;
`endif
                    end
                end
            end

            S_DATA: begin
                if (xfer) begin
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ bus.byte_in;
`endif
                    bcnt_d = bcnt_q + 2'd1;
                    case (bcnt_q)
                        2'd0: wbuf_d[7:0]   = bus.byte_in;
                        2'd1: wbuf_d[15:8]  = bus.byte_in;
                        2'd2: wbuf_d[23:16] = bus.byte_in;
                        default: begin
                            // Words beyond the RAM are consumed but dropped.
                            mem_we = in_range;
                            wcnt_d = wcnt_q + 16'd1;
                            if (wcnt_q + 16'd1 == len_q) begin
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
                                state_d = S_CSUM;
`else
                                state_d = S_DONE;
                                err_d   = len_ovf;
`endif
                            end
                        end
                    endcase
                end
            end

`ifdef SM_IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    state_d = S_DONE;
                    err_d   = len_ovf || (bus.byte_in != csum_q);
                end
            end
`endif

            default: state_d = S_IDLE;
        endcase
    end

    // Program RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign imData           = mem[imAddr[AW-1:0]];
    assign unused_addr_bits = ^imAddr[31:AW];

endmodule

// File: tb/tb_sm_imem_loader.sv
// Self-checking bench for sm_imem_loader: a SIZE=64 instance (a) and a
// SIZE=4 instance (b) for the overflow case. Expected RAM words are queued
// when the stream is built and compared through the read port afterwards.
module tb_sm_imem_loader;

`ifdef SM_IMEM_LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sm_imem_loader_if ifa();
    sm_imem_loader_if ifb();

    logic        busy_a, err_a, crn_a, busy_b, err_b, crn_b;
    logic [31:0] ia_a, id_a, ia_b, id_b;

    sm_imem_loader #(.SIZE(64)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa),
        .busy(busy_a), .err(err_a), .cpu_rst_n(crn_a),
        .imAddr(ia_a), .imData(id_a)
    );

    sm_imem_loader #(.SIZE(4)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb),
        .busy(busy_b), .err(err_b), .cpu_rst_n(crn_b),
        .imAddr(ia_b), .imData(id_b)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_a[$];
    exp_t        sb_b[$];
    logic [7:0]  stream[$];
    logic [31:0] words[8];
    int          nxfer;
    int          errors = 0;
    int          checks = 0;

    task automatic set_in(input bit sel, input logic lr, input logic [7:0] b, input logic v);
        if (sel) begin
            ifb.load_req = lr; ifb.byte_in = b; ifb.byte_valid = v;
        end else begin
            ifa.load_req = lr; ifa.byte_in = b; ifa.byte_valid = v;
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? ifb.byte_ready : ifa.byte_ready;
    endfunction

    // Present one byte until accepted; in gap mode an idle cycle (with an
    // ignored load_req pulse) precedes it.
    task automatic send_byte(input bit sel, input logic [7:0] b, input bit gap, output bit ok);
        bit got;
        got = 1'b0;
        if (gap) begin
            @(negedge clk);
            set_in(sel, 1'b1, b, 1'b0);
        end
        for (int t = 0; t < 32 && !got; t++) begin
            @(negedge clk);
            set_in(sel, 1'b0, b, 1'b1);
            got = rdy(sel);
            @(posedge clk);
            if (got) nxfer++;
        end
        ok = got;
    endtask

    // Pulse load_req for one edge; returns #1 after that edge.
    task automatic pulse_load(input bit sel);
        @(negedge clk);
        set_in(sel, 1'b1, 8'h00, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic build_stream(input int n, input bit bad_cs);
        logic [7:0]  cs;
        logic [15:0] len;
        logic [31:0] w;
        stream.delete();
        len = 16'(n);
        cs  = len[7:0] ^ len[15:8];
        stream.push_back(len[7:0]);
        stream.push_back(len[15:8]);
        for (int i = 0; i < n; i++) begin
            w = words[i];
            for (int j = 0; j < 4; j++) begin
                stream.push_back(w[8*j +: 8]);
                cs ^= w[8*j +: 8];
            end
        end
        if (CS != 0) stream.push_back(bad_cs ? ~cs : cs);
    endtask

    // Send the whole stream; span = cycles from first to last transfer edge.
    task automatic run_stream(input bit sel, input bit gap, output int xfers,
                              output int unsigned span, output bit ok);
        int unsigned c0;
        c0 = 0;
        ok = 1'b1;
        nxfer = 0;
        foreach (stream[i]) begin
            bit o;
            send_byte(sel, stream[i], gap, o);
            if (!o) ok = 1'b0;
            if (i == 0) begin
                #1;
                c0 = cyc;
            end
        end
        #1;
        span  = cyc - c0;
        xfers = nxfer;
        @(negedge clk);
        set_in(sel, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks += 5;
        if (crn_a !== 1'b0) begin errors++; $display("FAIL reset_crn: got %b want 0", crn_a); end
        if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        if (ifa.byte_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ifa.byte_ready); end
        if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_a); end
        if (crn_b !== 1'b0) begin errors++; $display("FAIL reset_crn_b: got %b want 0", crn_b); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks += 2;
        if (busy_a !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy_a); end
        if (crn_a !== 1'b0) begin errors++; $display("FAIL idle_crn: got %b want 0", crn_a); end
    endtask

    task automatic test_basic();
        int xf; int unsigned sp; bit ok; exp_t e;
        words[0] = 32'h24020005; words[1] = 32'h24420001;
        pulse_load(0);
        checks += 3;
        if (busy_a !== 1'b1) begin errors++; $display("FAIL basic_start_busy: got %b want 1", busy_a); end
        if (ifa.byte_ready !== 1'b1) begin errors++; $display("FAIL basic_start_ready: got %b want 1", ifa.byte_ready); end
        if (crn_a !== 1'b0) begin errors++; $display("FAIL basic_start_crn: got %b want 0", crn_a); end
        build_stream(2, 1'b0);
        sb_a.push_back('{32'd0, words[0]});
        sb_a.push_back('{32'd1, words[1]});
        sb_a.push_back('{32'd64, words[0]});
        run_stream(0, 1'b0, xf, sp, ok);
        checks += 6;
        if (!ok) begin errors++; $display("FAIL basic_timeout: byte not accepted within bound"); end
        if (xf != 10 + CS) begin errors++; $display("FAIL basic_xfers: got %0d want %0d", xf, 10 + CS); end
        if (sp != 32'(9 + CS)) begin errors++; $display("FAIL basic_span: got %0d want %0d", sp, 9 + CS); end
        if (busy_a !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b want 0", busy_a); end
        if (crn_a !== 1'b1) begin errors++; $display("FAIL basic_crn: got %b want 1", crn_a); end
        if (err_a !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", err_a); end
        while (sb_a.size() > 0) begin
            e = sb_a.pop_front();
            ia_a = e.addr;
            #1;
            checks++;
            if (id_a !== e.data) begin errors++; $display("FAIL basic_mem[%0d]: got %h want %h", e.addr, id_a, e.data); end
        end
    endtask

    task automatic test_back_to_back();
        int xf; int unsigned sp; bit ok; exp_t e;
        // Overwrite with other words first so the gapped load must rewrite them.
        words[0] = 32'h11111111; words[1] = 32'h22222222;
        pulse_load(0);
        checks++;
        if (crn_a !== 1'b0) begin errors++; $display("FAIL reload_crn: got %b want 0", crn_a); end
        build_stream(2, 1'b0);
        run_stream(0, 1'b0, xf, sp, ok);
        words[0] = 32'h24020005; words[1] = 32'h24420001;
        pulse_load(0);
        build_stream(2, 1'b0);
        sb_a.push_back('{32'd0, words[0]});
        sb_a.push_back('{32'd1, words[1]});
        run_stream(0, 1'b1, xf, sp, ok);
        checks += 5;
        if (!ok) begin errors++; $display("FAIL gap_timeout: byte not accepted within bound"); end
        if (xf != 10 + CS) begin errors++; $display("FAIL gap_xfers: got %0d want %0d", xf, 10 + CS); end
        if (busy_a !== 1'b0) begin errors++; $display("FAIL gap_busy: got %b want 0", busy_a); end
        if (crn_a !== 1'b1) begin errors++; $display("FAIL gap_crn: got %b want 1", crn_a); end
        if (err_a !== 1'b0) begin errors++; $display("FAIL gap_err: got %b want 0", err_a); end
        while (sb_a.size() > 0) begin
            e = sb_a.pop_front();
            ia_a = e.addr;
            #1;
            checks++;
            if (id_a !== e.data) begin errors++; $display("FAIL gap_mem[%0d]: got %h want %h", e.addr, id_a, e.data); end
        end
    endtask

    task automatic test_overflow();
        int xf; int unsigned sp; bit ok; exp_t e;
        for (int i = 0; i < 6; i++) words[i] = 32'hA5000000 + 32'(i * 32'h01010101);
        pulse_load(1);
        build_stream(6, 1'b0);
        for (int i = 0; i < 4; i++) sb_b.push_back('{32'(i), words[i]});
        run_stream(1, 1'b0, xf, sp, ok);
        checks += 5;
        if (!ok) begin errors++; $display("FAIL ovf_timeout: byte not accepted within bound"); end
        if (xf != 26 + CS) begin errors++; $display("FAIL ovf_xfers: got %0d want %0d", xf, 26 + CS); end
        if (err_b !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b want 1", err_b); end
        if (crn_b !== 1'b0) begin errors++; $display("FAIL ovf_crn: got %b want 0", crn_b); end
        if (busy_b !== 1'b0) begin errors++; $display("FAIL ovf_busy: got %b want 0", busy_b); end
        while (sb_b.size() > 0) begin
            e = sb_b.pop_front();
            ia_b = e.addr;
            #1;
            checks++;
            if (id_b !== e.data) begin errors++; $display("FAIL ovf_mem[%0d]: got %h want %h", e.addr, id_b, e.data); end
        end
    endtask

    task automatic test_reset_midload();
        int xf; int unsigned sp; bit ok;
        words[0] = 32'hDEADBEEF; words[1] = 32'hCAFEF00D;
        pulse_load(0);
        build_stream(2, 1'b0);
        nxfer = 0;
        for (int i = 0; i < 5; i++) send_byte(0, stream[i], 1'b0, ok);
        @(negedge clk);
        set_in(0, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        #1;
        ia_a = 32'd0;
        #1;
        checks += 6;
        if (busy_a !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy_a); end
        if (ifa.byte_ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b want 0", ifa.byte_ready); end
        if (crn_a !== 1'b0) begin errors++; $display("FAIL mid_crn: got %b want 0", crn_a); end
        if (err_b !== 1'b0) begin errors++; $display("FAIL mid_err_b: got %b want 0", err_b); end
        if (id_a !== 32'h24020005) begin errors++; $display("FAIL mid_mem0: got %h want 24020005", id_a); end
        if (nxfer != 5) begin errors++; $display("FAIL mid_xfers: got %0d want 5", nxfer); end
        @(negedge clk);
        rst_n = 1'b1;
        pulse_load(0);
        build_stream(0, 1'b0);
        run_stream(0, 1'b0, xf, sp, ok);
        checks += 4;
        if (xf != 2 + CS) begin errors++; $display("FAIL n0_xfers: got %0d want %0d", xf, 2 + CS); end
        if (crn_a !== 1'b1) begin errors++; $display("FAIL n0_crn: got %b want 1", crn_a); end
        if (err_a !== 1'b0) begin errors++; $display("FAIL n0_err: got %b want 0", err_a); end
        if (busy_a !== 1'b0) begin errors++; $display("FAIL n0_busy: got %b want 0", busy_a); end
    endtask

`ifdef SM_IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int xf; int unsigned sp; bit ok; exp_t e;
        words[0] = 32'h01234567; words[1] = 32'h89ABCDEF;
        pulse_load(0);
        build_stream(2, 1'b1);
        sb_a.push_back('{32'd0, words[0]});
        sb_a.push_back('{32'd1, words[1]});
        run_stream(0, 1'b0, xf, sp, ok);
        checks += 2;
        if (err_a !== 1'b1) begin errors++; $display("FAIL cs_bad_err: got %b want 1", err_a); end
        if (crn_a !== 1'b0) begin errors++; $display("FAIL cs_bad_crn: got %b want 0", crn_a); end
        while (sb_a.size() > 0) begin
            e = sb_a.pop_front();
            ia_a = e.addr;
            #1;
            checks++;
            if (id_a !== e.data) begin errors++; $display("FAIL cs_mem[%0d]: got %h want %h", e.addr, id_a, e.data); end
        end
        pulse_load(0);
        build_stream(2, 1'b0);
        run_stream(0, 1'b0, xf, sp, ok);
        checks += 2;
        if (err_a !== 1'b0) begin errors++; $display("FAIL cs_good_err: got %b want 0", err_a); end
        if (crn_a !== 1'b1) begin errors++; $display("FAIL cs_good_crn: got %b want 1", crn_a); end
    endtask
`endif

    initial begin
        set_in(0, 1'b0, 8'h00, 1'b0);
        set_in(1, 1'b0, 8'h00, 1'b0);
        ia_a = '0;
        ia_b = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_reset_midload();
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
